fetch_unit: RTL

//  Instruction-fetch stage directly upstream of the controller. Holds the PC
//  and reads instructions from instruction memory over a req/ready handshake.

---
 rtl/fetch_unit.sv | 85 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC + instruction register fetching over a req/ready handshake.
// Optional FETCH_TIMEOUT_EN adds a wait-cycle timeout that injects a NOP and sets fetch_err.
module fetch_unit #(
  parameter int INSTR_W = 19,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               enablePC,
  input  logic               rstPC,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [1:0]         lasttwoBits,
  output logic [2:0]         lastthreeBits,
  output logic [2:0]         threeBitFn,
  output logic [1:0]         twoBitFn,
  output logic               fetch_err
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, next;
  logic accept, retire, tmo;
  // A response only counts while our request is actually raised (not the cycle right after rstPC).
  assign accept = state == REQ && imem_req && imem_ready;
  assign retire = state == HOLD && enablePC;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo = state == REQ && imem_req && !imem_ready && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clock or posedge rst)
    if (rst) cnt <= '0;
    else if (rstPC || state != REQ || accept || tmo) cnt <= '0;
    else if (imem_req) cnt <= cnt + 1'b1;
  always_ff @(posedge clock or posedge rst)
    if (rst) fetch_err <= 1'b0;
    else if (rstPC) fetch_err <= 1'b0;
    else if (tmo) fetch_err <= 1'b1;
`else
  assign tmo = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_ff @(posedge clock or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb
    next = rstPC ? REQ : state == IDLE ? REQ : (accept || tmo) ? HOLD : retire ? REQ : state;
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      pc <= '0;
      instr <= '0;
      instr_valid <= 1'b0;
      imem_req <= 1'b0;
    end else if (rstPC) begin
      pc <= '0;
      instr_valid <= 1'b0;
      imem_req <= 1'b0;
    end else begin
      imem_req <= next == REQ;
      if (accept) begin
        instr <= imem_rdata;
        instr_valid <= 1'b1;
      end else if (tmo) begin
        instr <= '0;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        instr_valid <= 1'b0;
        pc <= jump_en ? jump_addr : pc + 1'b1;
      end
    end
  always_comb begin
    imem_addr = pc;
    lasttwoBits = instr[INSTR_W-1 -: 2];
    lastthreeBits = instr[INSTR_W-1 -: 3];
    threeBitFn = instr[INSTR_W-4 -: 3];
    twoBitFn = instr[INSTR_W-4 -: 2];
  end
endmodule
